// File: rtl/crypt_pkg.sv
// Shared definitions for the cripto/decripto pair: widths, crypto-window address bits,
// rotation helpers and the decryption FSM state type.
package crypt_pkg;

  localparam int unsigned W_DEF      = 10;
  localparam int unsigned ROUNDS_DEF = 4;

  // One-hot address bits within the 0x0000_0200 crypto window
  localparam int unsigned ADDR_TRNG_BIT       = 1;
  localparam int unsigned ADDR_SETPT_BIT      = 2;
  localparam int unsigned ADDR_GET_CIPHER_BIT = 3;
  localparam int unsigned ADDR_DEC_CT_BIT     = 4;
  localparam int unsigned ADDR_DEC_PT_BIT     = 5;
  localparam int unsigned ADDR_DEC_STAT_BIT   = 6;

  localparam int unsigned MAX_W = 32;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dec_state_e;

  // Rotate the low w bits of x left by n (mod w); bits at and above w are zero
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned n,
                                            input int unsigned w);
    logic [MAX_W-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) y[IDX_W'((i + n) % w)] = x[IDX_W'(i)];
    end
    return y;
  endfunction

  // Rotate the low w bits of x right by n (mod w)
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x,
                                            input int unsigned n,
                                            input int unsigned w);
    logic [MAX_W-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) y[IDX_W'(i)] = x[IDX_W'((i + n) % w)];
    end
    return y;
  endfunction

endpackage

// File: rtl/decripto_if.sv
// CPU-side bus of the decryption peripheral: access strobes, store data, key and status.
interface decripto_if
  import crypt_pkg::*;
#(
  parameter int unsigned W = W_DEF
) ();

  logic        sel;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [W-1:0] key;
  logic [31:0] rdata;
  logic        busy;
  logic        done;

  modport master (
    output sel, we, addr, wdata, key,
    input  rdata, busy, done
  );

  modport slave (
    input  sel, we, addr, wdata, key,
    output rdata, busy, done
  );

endinterface

// File: rtl/decripto_round.sv
// One inverse cipher round: x' = rotr1(x) ^ rotl(k, r).
module decripto_round
  import crypt_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned RW = 2
) (
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  k,
  input  logic [RW-1:0] r,
  output logic [W-1:0]  x_next
);

  assign x_next = W'(rotr(MAX_W'(x), 1, W)) ^ W'(rotl(MAX_W'(k), 32'(r), W));

endmodule

// File: rtl/decripto.sv
// Memory-mapped iterative decryptor: CT write snapshots the key and runs ROUNDS inverse
// rounds, one per clock, then latches the plaintext and raises a sticky done flag.
module decripto
  import crypt_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned ROUNDS = ROUNDS_DEF
) (
  input  logic      clk,
  input  logic      reset,
  decripto_if.slave bus
);

  localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  dec_state_e    state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  key_q, key_d;
  logic [W-1:0]  pt_q, pt_d;
  logic [RW-1:0] r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  x_round;
  logic          ct_wr_c;
  logic [31:0]   rdata_c;

  assign ct_wr_c = bus.sel & bus.we & bus.addr[ADDR_DEC_CT_BIT];

  decripto_round #(
    .W  (W),
    .RW (RW)
  ) u_round (
    .x      (x_q),
    .k      (key_q),
    .r      (r_q),
    .x_next (x_round)
  );

  // Next state: a CT write always (re)starts, aborting any run in progress
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    key_d   = key_q;
    pt_d    = pt_q;
    r_d     = r_q;
    if (ct_wr_c) begin
      state_d = ST_RUN;
      x_d     = W'(bus.wdata);
      key_d   = bus.key;
      r_d     = RW'(ROUNDS - 1);
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          x_d = x_round;
          if (r_q == '0) begin
            state_d = ST_DONE;
            pt_d    = x_round;
          end else begin
            r_d = r_q - RW'(1);
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read mux; the CT address is write-only and wins over the read addresses
  always_comb begin
    rdata_c = '0;
    if (bus.sel) begin
      if (bus.addr[ADDR_DEC_CT_BIT])        rdata_c = '0;
      else if (bus.addr[ADDR_DEC_PT_BIT])   rdata_c = 32'(pt_q);
      else if (bus.addr[ADDR_DEC_STAT_BIT]) rdata_c = 32'({done_q, busy_q});
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_decripto.sv
// Directed bench for decripto with a transaction-level reference model checked every cycle.
module tb_decripto;

  localparam int W      = 10;
  localparam int ROUNDS = 4;
  localparam int MASK   = (1 << W) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  decripto_if #(.W(W)) bus ();

  decripto #(.W(W), .ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rol(input int v, input int n);
    int s;
    s = n % W;
    return ((v << s) | (v >> (W - s))) & MASK;
  endfunction

  function automatic int ror(input int v, input int n);
    return rol(v, W - (n % W));
  endfunction

  function automatic int enc(input int pt, input int k);
    int x;
    x = pt & MASK;
    for (int r = 0; r < ROUNDS; r++) x = rol(x ^ rol(k, r), 1);
    return x;
  endfunction

  function automatic int dec(input int ct, input int k);
    int x;
    x = ct & MASK;
    for (int r = ROUNDS - 1; r >= 0; r--) x = ror(x, 1) ^ rol(k, r);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after each edge, abstracted as a pending result and a countdown
  int m_busy, m_done, m_pt, m_rem, m_res;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_pt = 0; m_rem = 0;
    end else if (bus.sel && bus.we && bus.addr[4]) begin
      m_res  = dec(int'(bus.wdata), int'(bus.key));
      m_rem  = ROUNDS;
      m_busy = 1;
      m_done = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
        m_pt   = m_res;
      end
    end
  end

  function automatic logic [31:0] model_rdata();
    if (!bus.sel)     return 32'h0;
    if (bus.addr[4])  return 32'h0;
    if (bus.addr[5])  return 32'(m_pt);
    if (bus.addr[6])  return 32'({m_done[0], m_busy[0]});
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("rdata", bus.rdata, model_rdata());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ct_write(input int ct, input int k);
    bus.key   = W'(k);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 8'h10;
    bus.wdata = 32'(ct);
    tick(1);
    bus.we    = 1'b0;
    bus.sel   = 1'b0;
    bus.addr  = 8'h00;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    check(name, bus.rdata, exp);
  endtask

  int ct_rt;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 32'h0; bus.key = '0;

    // Pin the model against hand-computed results
    check("model_k0_ct1", 32'(dec(1, 0)), 32'h040);
    check("model_k0_ct2", 32'(dec(2, 0)), 32'h080);
    check("model_k3ff_ct0", 32'(dec(0, 10'h3FF)), 32'h000);
    ct_rt = enc(10'h1C3, 10'h2A5);
    check("model_roundtrip", 32'(dec(ct_rt, 10'h2A5)), 32'h1C3);

    tick(3);
    reset = 1'b0;
    read_chk("reset_status", 8'h40, 32'h0);
    read_chk("reset_pt", 8'h20, 32'h0);

    // key 0, CT 0x001
    ct_write(1, 0);
    check("busy_after_start", 32'(bus.busy), 32'h1);
    tick(3);
    check("busy_at_n3", 32'(bus.busy), 32'h1);
    tick(1);
    read_chk("status_n4", 8'h40, 32'h2);
    read_chk("pt_k0_ct1", 8'h20, 32'h040);

    // key 0x3FF, CT 0; key input changes mid-run
    ct_write(0, 10'h3FF);
    bus.sel = 1'b1; bus.addr = 8'h20;
    tick(1);
    bus.key = W'(10'h155);
    tick(1);
    check("stale_pt_during_run", bus.rdata, 32'h040);
    tick(2);
    read_chk("pt_k3ff_ct0", 8'h20, 32'h000);

    // Round trip through the encrypt direction
    ct_write(ct_rt, 10'h2A5);
    tick(4);
    read_chk("pt_roundtrip", 8'h20, 32'h1C3);

    // Abort: second CT write two cycles after the first
    ct_write(1, 0);
    tick(1);
    ct_write(2, 0);
    tick(3);
    check("done_low_n5", 32'(bus.done), 32'h0);
    tick(1);
    check("done_high_n6", 32'(bus.done), 32'h1);
    read_chk("pt_abort", 8'h20, 32'h080);

    // Writes that must not start
    bus.sel = 1'b0; bus.we = 1'b1; bus.addr = 8'h10; bus.wdata = 32'h5;
    tick(1);
    check("unsel_no_start", 32'(bus.busy), 32'h0);
    bus.sel = 1'b1; bus.addr = 8'h20;
    tick(1);
    check("nonct_no_start", 32'(bus.busy), 32'h0);
    bus.we = 1'b0; bus.sel = 1'b0; bus.addr = 8'h20;
    #1;
    check("rdata_unsel", bus.rdata, 32'h0);
    read_chk("ct_addr_priority", 8'h70, 32'h0);

    // Reset mid-run
    ct_write(3, 10'h155);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    read_chk("rst_pt", 8'h20, 32'h0);
    tick(6);
    check("rst_stays_idle", 32'(bus.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decripto.md
# decripto

Memory-mapped decryption peripheral that inverts the team's 10-bit block cipher implemented by `cripto`. It sits beside `cripto` in the 0x0000_0200 crypto window. The CPU writes a ciphertext, the block runs an iterative multi-cycle round datapath using a snapshot of the TRNG key, and the CPU polls status before reading back the plaintext. It closes the encrypt/decrypt loop on the board, so ciphertext can be round-tripped from software.

## Interface
Parameters:
- `W`, 10: block and key width in bits.
- `ROUNDS`, 4: number of cipher rounds; must match `cripto`.

Ports:
- `clk`  in  1  system clock (the divided CPU clock).
- `reset`  in  1  synchronous, active-high reset. One clock domain; polarity and synchronicity are fixed.
- `sel`  in  1  access targets the crypto window (top drives `isCRPT`).
- `we`  in  1  CPU store strobe (`memwrite`).
- `addr`  in  8  low byte of the data address.
- `wdata`  in  32  store data; bits [W-1:0] are used.
- `key`  in  W  current TRNG key register from top.
- `rdata`  out  32  combinational read data, zero when not selected.
- `busy`  out  1  decryption in progress.
- `done`  out  1  sticky result-valid flag.

## Operation
- Register map (one-hot address bits inside the window):
  - `addr[4]` (0x210), write: load ciphertext, snapshot `key`, start.
  - `addr[5]` (0x220), read: `{22'b0, pt}`.
  - `addr[6]` (0x240), read: `{30'b0, done, busy}`.
- Address priority: `addr[4]` > `addr[5]` > `addr[6]`. Reads have no side effects.
- Cipher definition (shared with `cripto`):
  - Encrypt: for r = 0..ROUNDS-1, x = rotl1(x ^ rotl(k, r)).
  - Decrypt: for r = ROUNDS-1 down to 0, x = rotr1(x) ^ rotl(k, r).
  - All rotations are modulo W. There is no carry or widening.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on a CT write.
  - RUN: one round per cycle, and the round counter decrements. At r = 0, go to DONE and latch x into `pt`.
  - DONE → RUN on a new CT write.
- A CT write during RUN aborts the current operation and restarts with the new data and a new key snapshot. `done` clears on every CT write.
- A change on the `key` input after start has no effect on the current operation.
- Reset values: state IDLE, `pt`=0, x=0, key snapshot=0, `busy`=0, `done`=0, `rdata`=0 when unselected. Reset mid-RUN discards the operation.
- Reset has priority over a simultaneous CT write.

## Timing
- A CT write is sampled at edge N. After edge N: `busy`=1, x=ciphertext, r=ROUNDS-1.
- Edges N+1..N+ROUNDS each execute one round.
- After edge N+ROUNDS: `busy`=0, `done`=1, `pt` holds the result. Latency is ROUNDS cycles (4 by default).
- `pt` keeps its previous value until the new result lands. A read during RUN returns the stale `pt`.
- `rdata` is combinational from registers, so it is valid in the same cycle as the load instruction's address.

## Structure
- Shared package `crypt_pkg` holds:
  - `W` and `ROUNDS` defaults.
  - Crypto-window address bit constants (TRNG, SETPT, GET_CIPHER, DEC_CT, DEC_PT, DEC_STAT).
  - `rotl`/`rotr` functions.
  - FSM state enum.
- `cripto` imports the same package so both directions stay consistent.
- One sub-module, `decripto_round`: a purely combinational single inverse round (x, k, r → x').

## Test plan
- Reset, then read 0x240 and 0x220 → both 0. Then assert `reset` mid-RUN → `busy`=0, `done`=0, `pt`=0 on the next cycle.
- `key`=0x000, write CT 0x001 → `busy` high for 4 cycles. At N+4, status reads 0x2 and PT reads 0x040.
- `key`=0x3FF, write CT 0x000 → PT 0x000 after 4 cycles. The `key` input is changed to 0x155 at N+2, and the result is unaffected.
- Round trip: `key`=0x2A5, `cripto` encrypts plaintext 0x1C3, software writes the resulting ciphertext to 0x210 → PT reads 0x1C3.
- Write CT 0x001 (`key`=0), then write CT 0x002 at N+2 → `done` stays 0 until N+6, and PT reads 0x080.
- Unselected or non-CT writes (`sel`=0, or `addr[4]`=0) → no start, and `rdata`=0 when `sel`=0.
